// File: rtl/conv2d_psum_buf_pkg.sv
// Shared defaults, constants and state encodings for the conv2d partial-sum buffer.
package conv2d_psum_buf_pkg;

  localparam int CONV_A_WIDTH = 10;
  localparam int CONV_N_WIDTH = 10;

  localparam logic [31:0] FP32_ZERO = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic {
    SRC_REG = 1'b0,
    SRC_RAM = 1'b1
  } ysrc_e;

endpackage

// File: rtl/conv2d_psum_buf_if.sv
// Core-side bus of the partial-sum buffer: frame parameters, y/z accumulation and output stream.
interface conv2d_psum_buf_if
  import conv2d_psum_buf_pkg::*;
#(
  parameter int A_WIDTH = CONV_A_WIDTH,
  parameter int N_WIDTH = CONV_N_WIDTH
) ();

  logic               param_ena;
  logic [A_WIDTH:0]   param_npxl;
  logic [N_WIDTH-1:0] param_nchan;
  logic [31:0]        param_bias;
  logic               pxl_ena_y;
  logic [31:0]        pxl_y;
  logic               pxl_ena_z;
  logic [31:0]        pxl_z;
  logic               out_ena;
  logic [31:0]        out_data;
  logic               busy;
  logic               done;
  logic               err;

  modport master (
    output param_ena, param_npxl, param_nchan, param_bias, pxl_ena_y, pxl_ena_z, pxl_z,
    input  pxl_y, out_ena, out_data, busy, done, err
  );

  modport slave (
    input  param_ena, param_npxl, param_nchan, param_bias, pxl_ena_y, pxl_ena_z, pxl_z,
    output pxl_y, out_ena, out_data, busy, done, err
  );

endinterface

// File: rtl/conv2d_psum_buf_psum_ram.sv
// Simple dual-port partial-sum store with a registered, read-enabled output (block-RAM friendly).
module psum_ram
  import conv2d_psum_buf_pkg::*;
#(
  parameter int A_WIDTH = CONV_A_WIDTH
) (
  input  logic               clk_i,
  input  logic               we_i,
  input  logic [A_WIDTH-1:0] waddr_i,
  input  logic [31:0]        wdata_i,
  input  logic               re_i,
  input  logic [A_WIDTH-1:0] raddr_i,
  output logic [31:0]        rdata_o
);

  logic [31:0] mem_q [2**A_WIDTH];
  logic [31:0] rdata_q;

  // Read data only updates on an enabled read so it holds between requests.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/conv2d_psum_buf.sv
// Partial-sum responder for the conv2d core: serves y sums, stores z results, forwards the last channel.
module conv2d_psum_buf
  import conv2d_psum_buf_pkg::*;
#(
  parameter int A_WIDTH = CONV_A_WIDTH,
  parameter int N_WIDTH = CONV_N_WIDTH
) (
  input logic             clk,
  input logic             rst,
  conv2d_psum_buf_if.slave bus
);

  localparam logic [A_WIDTH:0]   NPXL_ONE = {{A_WIDTH{1'b0}}, 1'b1};
  localparam logic [A_WIDTH-1:0] ADDR_ONE = {{(A_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [N_WIDTH-1:0] CHAN_ONE = {{(N_WIDTH-1){1'b0}}, 1'b1};

  state_e             state_q;
  ysrc_e              ysrc_q;
  logic [A_WIDTH:0]   npxl_q;
  logic [N_WIDTH-1:0] nchan_q;
  logic [31:0]        bias_q;
  logic [A_WIDTH-1:0] rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
  logic [N_WIDTH-1:0] rd_chan_q, rd_chan_d, wr_chan_q, wr_chan_d;
  logic [31:0]        pxl_y_q, out_data_q, ram_rdata;
  logic               out_ena_q, busy_q, done_q, err_q;
  logic               run, rd_wrap, wr_wrap, rd_ok, wr_ok, wr_last_chan;
  logic               ram_we, ram_re, bypass, hazard;

  always_comb begin
    rd_wrap      = ({1'b0, rd_addr_q} == npxl_q - NPXL_ONE);
    wr_wrap      = ({1'b0, wr_addr_q} == npxl_q - NPXL_ONE);
    rd_addr_d    = rd_wrap ? '0 : rd_addr_q + ADDR_ONE;
    rd_chan_d    = rd_wrap ? rd_chan_q + CHAN_ONE : rd_chan_q;
    wr_addr_d    = wr_wrap ? '0 : wr_addr_q + ADDR_ONE;
    wr_chan_d    = wr_wrap ? wr_chan_q + CHAN_ONE : wr_chan_q;
    run          = (state_q == ST_RUN) && !bus.param_ena;
    rd_ok        = run && bus.pxl_ena_y && (rd_chan_q != nchan_q);
    wr_ok        = run && bus.pxl_ena_z && (wr_chan_q != nchan_q);
    wr_last_chan = (wr_chan_q == nchan_q - CHAN_ONE);
    ram_we       = wr_ok && !wr_last_chan;
    // A read of the address being written this cycle takes the fresh z value instead of stale RAM.
    bypass       = ram_we && rd_ok && (rd_chan_q != '0) && (rd_addr_q == wr_addr_q);
    ram_re       = rd_ok && (rd_chan_q != '0) && !bypass;
    hazard       = rd_ok && (rd_chan_q > wr_chan_q) && (rd_addr_q >= wr_addr_q) && !bypass;
  end

  psum_ram #(.A_WIDTH(A_WIDTH)) u_psum_ram (
    .clk_i   (clk),
    .we_i    (ram_we),
    .waddr_i (wr_addr_q),
    .wdata_i (bus.pxl_z),
    .re_i    (ram_re),
    .raddr_i (rd_addr_q),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ysrc_q     <= SRC_REG;
      npxl_q     <= '0;
      nchan_q    <= '0;
      bias_q     <= FP32_ZERO;
      rd_addr_q  <= '0;
      rd_chan_q  <= '0;
      wr_addr_q  <= '0;
      wr_chan_q  <= '0;
      pxl_y_q    <= FP32_ZERO;
      out_data_q <= FP32_ZERO;
      out_ena_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      out_ena_q <= 1'b0;
      if (bus.param_ena) begin
        done_q <= 1'b0;
        if (bus.param_npxl == '0 || bus.param_nchan == '0) begin
          err_q   <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end else begin
          npxl_q    <= bus.param_npxl;
          nchan_q   <= bus.param_nchan;
          bias_q    <= bus.param_bias;
          rd_addr_q <= '0;
          rd_chan_q <= '0;
          wr_addr_q <= '0;
          wr_chan_q <= '0;
          err_q     <= 1'b0;
          busy_q    <= 1'b1;
          state_q   <= ST_RUN;
        end
      end else begin
        case (state_q)
          ST_RUN: begin
            if (bus.pxl_ena_y) begin
              if (!rd_ok) begin
                pxl_y_q <= FP32_ZERO;
                ysrc_q  <= SRC_REG;
                err_q   <= 1'b1;
              end else begin
                rd_addr_q <= rd_addr_d;
                rd_chan_q <= rd_chan_d;
                if (hazard) err_q <= 1'b1;
                if (rd_chan_q == '0) begin
                  pxl_y_q <= bias_q;
                  ysrc_q  <= SRC_REG;
                end else if (bypass) begin
                  pxl_y_q <= bus.pxl_z;
                  ysrc_q  <= SRC_REG;
                end else begin
                  ysrc_q  <= SRC_RAM;
                end
              end
            end
            // The final channel never lands in RAM; it leaves as the output stream.
            if (bus.pxl_ena_z) begin
              if (!wr_ok) begin
                err_q <= 1'b1;
              end else begin
                wr_addr_q <= wr_addr_d;
                wr_chan_q <= wr_chan_d;
                if (wr_last_chan) begin
                  out_ena_q  <= 1'b1;
                  out_data_q <= bus.pxl_z;
                  if (wr_wrap) begin
                    state_q <= ST_DONE;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                  end
                end
              end
            end
          end
          ST_DONE: begin
            done_q  <= 1'b0;
            state_q <= ST_IDLE;
            if (bus.pxl_ena_y || bus.pxl_ena_z) err_q <= 1'b1;
          end
          default: begin
            state_q <= ST_IDLE;
            if (bus.pxl_ena_y || bus.pxl_ena_z) err_q <= 1'b1;
          end
        endcase
      end
    end
  end

  assign bus.pxl_y    = (ysrc_q == SRC_RAM) ? ram_rdata : pxl_y_q;
  assign bus.out_ena  = out_ena_q;
  assign bus.out_data = out_data_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_conv2d_psum_buf.sv
// Directed self-checking bench for conv2d_psum_buf with hand-computed expected values.
module tb_conv2d_psum_buf;
  import conv2d_psum_buf_pkg::*;

  localparam int AW = CONV_A_WIDTH;
  localparam int NW = CONV_N_WIDTH;

  logic clk = 1'b0;
  logic rst;
  int   vecCount  = 0;
  int   missCount = 0;

  conv2d_psum_buf_if #(.A_WIDTH(AW), .N_WIDTH(NW)) bus ();

  conv2d_psum_buf #(.A_WIDTH(AW), .N_WIDTH(NW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecCount++;
    if (obs !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic y, input logic z, input logic [31:0] zd);
    bus.pxl_ena_y = y;
    bus.pxl_ena_z = z;
    bus.pxl_z     = zd;
    step();
    bus.pxl_ena_y = 1'b0;
    bus.pxl_ena_z = 1'b0;
  endtask

  task automatic applyParams(input logic [AW:0] npxl, input logic [NW-1:0] nchan,
                             input logic [31:0] bias);
    bus.param_ena   = 1'b1;
    bus.param_npxl  = npxl;
    bus.param_nchan = nchan;
    bus.param_bias  = bias;
    step();
    bus.param_ena = 1'b0;
  endtask

  logic [31:0] fp [4];
  logic [31:0] chA [3];
  logic [31:0] chB [3];
  logic [31:0] chC [3];

  initial begin
    fp  = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000};
    chA = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333};
    chB = '{32'h4444_4444, 32'h5555_5555, 32'h6666_6666};
    chC = '{32'h7777_7777, 32'h8888_8888, 32'h9999_9999};
    bus.param_ena   = 1'b0;
    bus.param_npxl  = '0;
    bus.param_nchan = '0;
    bus.param_bias  = '0;
    bus.pxl_ena_y   = 1'b0;
    bus.pxl_ena_z   = 1'b0;
    bus.pxl_z       = '0;
    rst = 1'b1;
    repeat (3) step();
    checkOutput("rst pxl_y", bus.pxl_y, 32'h0);
    checkOutput("rst out_ena", {31'b0, bus.out_ena}, 32'h0);
    checkOutput("rst out_data", bus.out_data, 32'h0);
    checkOutput("rst busy", {31'b0, bus.busy}, 32'h0);
    checkOutput("rst done", {31'b0, bus.done}, 32'h0);
    checkOutput("rst err", {31'b0, bus.err}, 32'h0);
    rst = 1'b0;

    // Single channel: bias on every read, every z straight to the output
    applyParams(11'd4, 10'd1, 32'h3F80_0000);
    checkOutput("t1 busy", {31'b0, bus.busy}, 32'h1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b0, 32'h0);
      checkOutput("t1 pxl_y bias", bus.pxl_y, 32'h3F80_0000);
    end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b1, fp[i]);
      checkOutput("t1 out_ena", {31'b0, bus.out_ena}, 32'h1);
      checkOutput("t1 out_data", bus.out_data, fp[i]);
      checkOutput("t1 done", {31'b0, bus.done}, (i == 3) ? 32'h1 : 32'h0);
    end
    checkOutput("t1 busy fell", {31'b0, bus.busy}, 32'h0);
    step();
    checkOutput("t1 done cleared", {31'b0, bus.done}, 32'h0);
    checkOutput("t1 out_ena cleared", {31'b0, bus.out_ena}, 32'h0);
    checkOutput("t1 out_data held", bus.out_data, 32'h4080_0000);

    // Three channels: stored sums come back on the following channel
    applyParams(11'd3, 10'd3, 32'h0);
    for (int p = 0; p < 3; p++) begin
      applyStimulus(1'b1, 1'b0, 32'h0);
      checkOutput("t2 ch0 bias", bus.pxl_y, 32'h0);
      applyStimulus(1'b0, 1'b1, chA[p]);
      checkOutput("t2 ch0 no out", {31'b0, bus.out_ena}, 32'h0);
    end
    for (int p = 0; p < 3; p++) begin
      applyStimulus(1'b1, 1'b0, 32'h0);
      checkOutput("t2 ch1 read", bus.pxl_y, chA[p]);
      applyStimulus(1'b0, 1'b1, chB[p]);
    end
    for (int p = 0; p < 3; p++) begin
      applyStimulus(1'b1, 1'b0, 32'h0);
      checkOutput("t2 ch2 read", bus.pxl_y, chB[p]);
      applyStimulus(1'b0, 1'b1, chC[p]);
      checkOutput("t2 ch2 out_ena", {31'b0, bus.out_ena}, 32'h1);
      checkOutput("t2 ch2 out_data", bus.out_data, chC[p]);
    end
    checkOutput("t2 done", {31'b0, bus.done}, 32'h1);
    checkOutput("t2 err", {31'b0, bus.err}, 32'h0);

    // Single pixel: channel-1 read collides with the channel-0 write
    applyParams(11'd1, 10'd2, 32'h3F00_0000);
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("t3 ch0 bias", bus.pxl_y, 32'h3F00_0000);
    applyStimulus(1'b1, 1'b1, 32'hCAFE_F00D);
    checkOutput("t3 bypass", bus.pxl_y, 32'hCAFE_F00D);
    checkOutput("t3 err", {31'b0, bus.err}, 32'h0);
    applyStimulus(1'b0, 1'b1, 32'h1234_5678);
    checkOutput("t3 out_data", bus.out_data, 32'h1234_5678);
    checkOutput("t3 done", {31'b0, bus.done}, 32'h1);

    // Full-size map streamed back to back, crossing the 1023 -> 0 wrap
    applyParams(11'd1024, 10'd2, 32'h4049_0FDB);
    for (int i = 0; i < 1024; i++) begin
      applyStimulus(1'b1, 1'b0, 32'h0);
      checkOutput("t4 ch0 bias", bus.pxl_y, 32'h4049_0FDB);
    end
    for (int i = 0; i < 1024; i++) applyStimulus(1'b0, 1'b1, 32'hA500_0000 + i);
    for (int i = 0; i < 1024; i++) begin
      applyStimulus(1'b1, 1'b0, 32'h0);
      checkOutput("t4 ch1 read", bus.pxl_y, 32'hA500_0000 + i);
    end
    checkOutput("t4 err after reads", {31'b0, bus.err}, 32'h0);
    for (int i = 0; i < 1024; i++) begin
      applyStimulus(1'b0, 1'b1, 32'h5A00_0000 + i);
      checkOutput("t4 out_data", bus.out_data, 32'h5A00_0000 + i);
    end
    checkOutput("t4 done", {31'b0, bus.done}, 32'h1);
    checkOutput("t4 err", {31'b0, bus.err}, 32'h0);

    // Over-read once all sums are issued: zero data, sticky error
    applyParams(11'd2, 10'd1, 32'h3F80_0000);
    applyStimulus(1'b1, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("t5 last read", bus.pxl_y, 32'h3F80_0000);
    checkOutput("t5 err before", {31'b0, bus.err}, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("t5 overread y", bus.pxl_y, 32'h0);
    checkOutput("t5 overread err", {31'b0, bus.err}, 32'h1);
    applyStimulus(1'b0, 1'b1, 32'h3F80_0000);
    applyStimulus(1'b0, 1'b1, 32'h4000_0000);
    checkOutput("t5 out_data", bus.out_data, 32'h4000_0000);
    checkOutput("t5 done", {31'b0, bus.done}, 32'h1);
    step();
    checkOutput("t5 err sticky", {31'b0, bus.err}, 32'h1);
    applyParams(11'd2, 10'd1, 32'h0);
    checkOutput("t5 err cleared", {31'b0, bus.err}, 32'h0);

    // Reset in the middle of channel 1, then a clean frame
    applyParams(11'd2, 10'd2, 32'h3F80_0000);
    applyStimulus(1'b1, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 32'hDEAD_0001);
    applyStimulus(1'b1, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 32'hDEAD_0002);
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("t6 ch1 read", bus.pxl_y, 32'hDEAD_0001);
    rst = 1'b1;
    step();
    rst = 1'b0;
    checkOutput("t6 rst pxl_y", bus.pxl_y, 32'h0);
    checkOutput("t6 rst busy", {31'b0, bus.busy}, 32'h0);
    checkOutput("t6 rst out_ena", {31'b0, bus.out_ena}, 32'h0);
    checkOutput("t6 rst err", {31'b0, bus.err}, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("t6 idle req err", {31'b0, bus.err}, 32'h1);
    checkOutput("t6 idle pxl_y held", bus.pxl_y, 32'h0);
    applyParams(11'd0, 10'd2, 32'h0);
    checkOutput("t6 npxl0 err", {31'b0, bus.err}, 32'h1);
    checkOutput("t6 npxl0 idle", {31'b0, bus.busy}, 32'h0);
    applyParams(11'd2, 10'd2, 32'h4000_0000);
    checkOutput("t6 new frame err", {31'b0, bus.err}, 32'h0);
    for (int p = 0; p < 2; p++) begin
      applyStimulus(1'b1, 1'b0, 32'h0);
      checkOutput("t6 ch0 bias", bus.pxl_y, 32'h4000_0000);
      applyStimulus(1'b0, 1'b1, 32'hB000_0000 + p);
    end
    for (int p = 0; p < 2; p++) begin
      applyStimulus(1'b1, 1'b0, 32'h0);
      checkOutput("t6 ch1 read", bus.pxl_y, 32'hB000_0000 + p);
      applyStimulus(1'b0, 1'b1, 32'hC000_0000 + p);
      checkOutput("t6 out_data", bus.out_data, 32'hC000_0000 + p);
    end
    checkOutput("t6 done", {31'b0, bus.done}, 32'h1);
    checkOutput("t6 err", {31'b0, bus.err}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
